// File: rtl/bcd_scan_7seg_if.sv
// Display-driver bus: BCD load strobe in, multiplexed segment/digit drive and error flag out.
interface bcd_scan_7seg_if;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic [7:0] seg;
  logic [1:0] dig;
  logic       err;

  // Upstream producer / display consumer side.
  modport master (
    output bcd_in,
    output bcd_valid,
    input  seg,
    input  dig,
    input  err
  );

  // Display driver side.
  modport slave (
    input  bcd_in,
    input  bcd_valid,
    output seg,
    output dig,
    output err
  );
endinterface

// File: rtl/bcd_scan_7seg.sv
// Two-digit multiplexed 7-segment driver. The BCD word is captured into a shadow register and
// copied to the active register only at frame boundaries, so a frame never mixes two words.
// Each digit slot begins with a blank interval so the previous digit's pattern cannot ghost.
module bcd_scan_7seg #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 500,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  bcd_scan_7seg_if.slave  disp_io
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
  localparam logic [7:0] SegOff = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [1:0] DigOff = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            idx_q, idx_d;
  logic [7:0]      shadow_q, shadow_d;
  logic            pend_q, pend_d;
  logic [7:0]      active_q, active_d;
  logic [7:0]      seg_q, seg_d;
  logic [1:0]      dig_q, dig_d;
  logic            err_q, err_d;

  logic       wrap;
  logic       frame_end;
  logic [3:0] nib;
  logic       lz_blank;
  logic [7:0] seg_hi;
  logic [1:0] dig_hi;

  // Active-high segment pattern; a..g in bits 0..6, dash for non-decimal nibbles.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  assign wrap      = (cnt_q == CntMax);
  assign frame_end = wrap & idx_q;

  // Slot counter and digit index; index flips on every counter wrap.
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? ~idx_q : idx_q;
  end

  // Double buffer: a strobe always lands in the shadow; a strobe on the boundary cycle stays
  // pending because the transfer below reads the pre-edge shadow.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    active_d = active_q;
    if (frame_end && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    if (disp_io.bcd_valid) begin
      shadow_d = disp_io.bcd_in;
      pend_d   = 1'b1;
    end
  end

  // Output pattern for the current slot, computed in active-high form then polarity-adjusted.
  always_comb begin
    nib      = idx_q ? active_q[7:4] : active_q[3:0];
    lz_blank = BLANK_LZ && idx_q && (active_q[7:4] == 4'd0);
    seg_hi   = 8'h00;
    dig_hi   = 2'b00;
    if (!lz_blank) begin
      seg_hi = {1'b0, seg_decode(nib)};
      if (cnt_q >= BlankEnd) begin
        dig_hi = idx_q ? 2'b10 : 2'b01;
      end
    end
    seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    dig_d = ACTIVE_LOW ? ~dig_hi : dig_hi;
    err_d = (active_q[7:4] > 4'd9) || (active_q[3:0] > 4'd9);
  end

  // Scan timing and word buffering state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 1'b0;
      shadow_q <= 8'h00;
      pend_q   <= 1'b0;
      active_q <= 8'h00;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      active_q <= active_d;
    end
  end

  // Registered display outputs; reset drives them to the off level immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SegOff;
      dig_q <= DigOff;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      err_q <= err_d;
    end
  end

  assign disp_io.seg = seg_q;
  assign disp_io.dig = dig_q;
  assign disp_io.err = err_q;

endmodule
